// File: rtl/core_pkg.sv
// Shared arbiter encodings: FSM states, memory owner, default starvation limit.
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MEM  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam int unsigned ARB_MAX_WAIT  = 4;
    localparam int unsigned ARB_CNT_WIDTH = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between instruction-fetch and data ports.
// Data wins by default; a starvation counter forces an instruction grant.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = ARB_MAX_WAIT,
    parameter int unsigned CNT_WIDTH = ARB_CNT_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic        i_req,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic        d_wen,
    input  logic        d_ren,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [CNT_WIDTH-1:0] MAX_WAIT_C = CNT_WIDTH'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_wmask_q, mem_wmask_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_valid_q, mem_valid_d;
    logic [31:0]          i_rdata_q, i_rdata_d;
    logic [31:0]          d_rdata_q, d_rdata_d;
    logic                 i_ready_q, i_ready_d;
    logic                 d_ready_q, d_ready_d;

    logic d_pend_c;
    logic force_i_c;

    assign d_pend_c  = d_wen | d_ren;
    assign force_i_c = i_req && (cnt_q >= MAX_WAIT_C);

    // Arbitration, memory handshake and starvation counter.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        mem_we_d    = mem_we_q;
        mem_valid_d = mem_valid_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (d_pend_c && !force_i_c) begin
                    owner_d     = OWN_D;
                    state_d     = ARB_MEM;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = d_addr;
                    // A simultaneous load+store is issued as the store.
                    mem_we_d    = d_wen;
                    mem_wdata_d = d_wen ? d_wdata : 32'd0;
                    mem_wmask_d = d_wen ? d_wmask : 4'd0;
                    if (!i_req) begin
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else if (i_req) begin
                    owner_d     = OWN_I;
                    state_d     = ARB_MEM;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = i_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 32'd0;
                    mem_wmask_d = 4'd0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            ARB_MEM: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ARB_RESP;
                    if (owner_q == OWN_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_I;
            cnt_q       <= '0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            mem_we_q    <= mem_we_d;
            mem_valid_q <= mem_valid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_we    = mem_we_q;
    assign mem_valid = mem_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; bench plays both requesters and the memory.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] i_addr;
    logic        i_req;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_wen;
    logic        d_ren;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_we;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int tests  = 0;
    int failed = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_addr    (i_addr),
        .i_req     (i_req),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_wen     (d_wen),
        .d_ren     (d_ren),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_we    (mem_we),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] any;
        any = i_rdata | d_rdata | mem_addr | mem_wdata | 32'(mem_wmask)
            | 32'(mem_we) | 32'(mem_valid) | 32'(i_ready) | 32'(d_ready);
        check(tag, any, 32'd0);
    endtask

    int d_grants;
    int i_grants;
    int i_readies;
    logic [31:0] exp_addr;
    logic [31:0] wdata_v;

    initial begin
        reset = 1'b0; i_addr = '0; i_req = 1'b0; d_addr = '0; d_wdata = '0;
        d_wmask = '0; d_wen = 1'b0; d_ren = 1'b0; mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        check_all_zero("reset_outputs");
        reset = 1'b1;

        // 1: lone instruction fetch, 2 memory wait cycles
        i_req = 1'b1; i_addr = 32'h100;
        tick();
        check("t1_valid", 32'(mem_valid), 32'd1);
        check("t1_we", 32'(mem_we), 32'd0);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_wmask", 32'(mem_wmask), 32'd0);
        tick(); tick();
        check("t1_valid_held", 32'(mem_valid), 32'd1);
        check("t1_no_early_ready", 32'(i_ready), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        check("t1_i_ready", 32'(i_ready), 32'd1);
        check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        check("t1_d_ready", 32'(d_ready), 32'd0);
        check("t1_valid_drop", 32'(mem_valid), 32'd0);
        i_req = 1'b0;
        tick();
        check("t1_i_ready_pulse", 32'(i_ready), 32'd0);
        check("t1_i_rdata_hold", i_rdata, 32'hDEADBEEF);

        // 2: simultaneous I and D load -> D first, counter 1, then I
        i_req = 1'b1; i_addr = 32'h100; d_ren = 1'b1; d_addr = 32'h200;
        tick();
        check("t2_d_first_addr", mem_addr, 32'h200);
        check("t2_d_first_we", 32'(mem_we), 32'd0);
        check("t2_cnt_after_d", 32'(dut.cnt_q), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        tick();
        mem_ready = 1'b0;
        check("t2_d_ready", 32'(d_ready), 32'd1);
        check("t2_i_ready_excl", 32'(i_ready), 32'd0);
        check("t2_d_rdata", d_rdata, 32'hAAAA5555);
        d_ren = 1'b0;
        tick();
        check("t2_cnt_before_i", 32'(dut.cnt_q), 32'd1);
        check("t2_idle_gap", 32'(mem_valid), 32'd0);
        tick();
        check("t2_i_grant_addr", mem_addr, 32'h100);
        check("t2_cnt_after_i", 32'(dut.cnt_q), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ready = 1'b0;
        check("t2_i_ready", 32'(i_ready), 32'd1);
        check("t2_i_rdata", i_rdata, 32'h11112222);
        i_req = 1'b0;
        tick();

        // 3: masked store held across 3 wait cycles; d_rdata keeps last load
        d_wen = 1'b1; d_addr = 32'h300; d_wmask = 4'b0011; d_wdata = 32'h12345678;
        tick();
        d_wdata = 32'h0; d_wmask = 4'b0; d_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            check("t3_we", 32'(mem_we), 32'd1);
            check("t3_wmask", 32'(mem_wmask), 32'h3);
            check("t3_wdata", mem_wdata, 32'h12345678);
            check("t3_addr", mem_addr, 32'h300);
            check("t3_valid", 32'(mem_valid), 32'd1);
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ready = 1'b0;
        check("t3_d_ready", 32'(d_ready), 32'd1);
        check("t3_d_rdata_kept", d_rdata, 32'hAAAA5555);
        d_wen = 1'b0;
        tick();
        check("t3_d_ready_pulse", 32'(d_ready), 32'd0);

        // 4: continuous D load vs I fetch: D,D,D,D,I repeating
        d_ren = 1'b1; d_addr = 32'h400; i_req = 1'b1; i_addr = 32'h100;
        d_grants = 0; i_grants = 0; i_readies = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            exp_addr = ((n % 5) == 4) ? 32'h100 : 32'h400;
            check($sformatf("t4_grant%0d", n), mem_addr, exp_addr);
            if (mem_addr == 32'h400) d_grants++;
            if (mem_addr == 32'h100) i_grants++;
            mem_ready = 1'b1; mem_rdata = 32'(n);
            tick();
            mem_ready = 1'b0;
            if (i_ready) i_readies++;
            tick();
        end
        check("t4_d_grants", 32'(d_grants), 32'd8);
        check("t4_i_grants", 32'(i_grants), 32'd2);
        check("t4_i_readies", 32'(i_readies), 32'd2);
        d_ren = 1'b0; i_req = 1'b0;
        tick();

        // 5: reset mid-transaction abandons it
        d_ren = 1'b1; d_addr = 32'h600;
        tick();
        check("t5_valid_before", 32'(mem_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("t5_async_reset");
        d_ren = 1'b0;
        tick();
        reset = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5_no_ready_after_reset", 32'(i_ready | d_ready | mem_valid), 32'd0);
            tick();
        end
        check("t5_d_rdata_cleared", d_rdata, 32'd0);
        i_req = 1'b1; i_addr = 32'h700;
        tick();
        check("t5_regrant_addr", mem_addr, 32'h700);
        check("t5_regrant_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hC0DE0001;
        tick();
        mem_ready = 1'b0;
        check("t5_i_ready", 32'(i_ready), 32'd1);
        check("t5_i_rdata", i_rdata, 32'hC0DE0001);
        i_req = 1'b0;
        tick();

        // 6: d_wen and d_ren together -> one write, one d_ready pulse
        wdata_v = 32'hCAFEF00D;
        d_wen = 1'b1; d_ren = 1'b1; d_addr = 32'h500; d_wdata = wdata_v; d_wmask = 4'hF;
        tick();
        check("t6_we", 32'(mem_we), 32'd1);
        check("t6_wdata", mem_wdata, wdata_v);
        check("t6_wmask", 32'(mem_wmask), 32'hF);
        mem_ready = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_ready = 1'b0;
        check("t6_d_ready", 32'(d_ready), 32'd1);
        check("t6_d_rdata_kept", d_rdata, 32'd0);
        d_wen = 1'b0; d_ren = 1'b0;
        tick();
        check("t6_pulse_end", 32'(d_ready), 32'd0);
        tick();
        check("t6_no_second", 32'(d_ready | mem_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
